// File: rtl/cache_if.sv
// cache_if: CPU request/response and backing-memory signals for cache_ctrl.
// Macro CACHE_STATS_EN adds the hit_count/miss_count statistics outputs.
interface cache_if #(parameter int BIT_WIDTH = 32);
    logic cpu_req, cpu_we, cpu_ready, cpu_busy, memwrite;
    logic [BIT_WIDTH-1:0] cpu_addr, cpu_wdata, cpu_rdata, addr, writedata, memdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, memdata,
        input cpu_ready, cpu_rdata, cpu_busy, memwrite, addr, writedata, hit_count, miss_count
    );
    modport slave (
        input cpu_req, cpu_we, cpu_addr, cpu_wdata, memdata,
        output cpu_ready, cpu_rdata, cpu_busy, memwrite, addr, writedata, hit_count, miss_count
    );
`else
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, memdata,
        input cpu_ready, cpu_rdata, cpu_busy, memwrite, addr, writedata
    );
    modport slave (
        input cpu_req, cpu_we, cpu_addr, cpu_wdata, memdata,
        output cpu_ready, cpu_rdata, cpu_busy, memwrite, addr, writedata
    );
`endif
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped one-word-per-line write-through, no-write-allocate cache.
// Macro CACHE_STATS_EN enables saturating LOOKUP hit/miss counters.
module cache_ctrl #(
    parameter int BIT_WIDTH  = 32,
    parameter int INDEX_BITS = 4
) (
    input logic   clk,
    input logic   reset,
    cache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = BIT_WIDTH - INDEX_BITS;
    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;
    state_t state, state_nxt;
    logic we_q, ready_q, hit, rd_hit;
    logic [BIT_WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [BIT_WIDTH-1:0] data_mem [LINES];
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0] tag;
    assign idx    = addr_q[INDEX_BITS-1:0];
    assign tag    = addr_q[BIT_WIDTH-1:INDEX_BITS];
    assign hit    = valid[idx] && tag_mem[idx] == tag;
    assign rd_hit = state == LOOKUP && !we_q && hit;
    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE) state_nxt = bus.cpu_req ? LOOKUP : IDLE;
        else if (state == LOOKUP) state_nxt = we_q ? WRITE : hit ? IDLE : FILL;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            valid   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= rd_hit || state == FILL || state == WRITE;
            if (state == IDLE && bus.cpu_req) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
            end
            if (rd_hit) rdata_q <= data_mem[idx];
            if (state == FILL) begin
                rdata_q    <= bus.memdata;
                valid[idx] <= 1'b1;
            end
        end
    // Tag/data arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk)
        if (state == FILL) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= bus.memdata;
        end else if (state == WRITE && hit) data_mem[idx] <= wdata_q;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == LOOKUP) begin
            if (hit && ~&hit_q) hit_q <= hit_q + 32'd1;
            if (!hit && ~&miss_q) miss_q <= miss_q + 32'd1;
        end
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
`endif
    assign bus.cpu_ready = ready_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_busy  = state != IDLE;
    assign bus.memwrite  = state == WRITE;
    assign bus.addr      = addr_q;
    assign bus.writedata = wdata_q;
endmodule
